seg_scan_595: RTL and testbench

- Parametrised multiplexed 7-segment driver with integrated binary-to-BCD conversion and 74HC595 serial output.
- Takes a binary magnitude, sign flag, per-digit decimal points and enable. Scans DIGITS digits and shifts each {sel, seg} word into the cascaded 595s.
- Replaces the fixed 6-digit seg_dynamic + hc595 pair.
- Adds a generic digit count, frame-synchronous snapshot, overflow indication and leading-zero blanking with a floating minus sign.

---
 rtl/seg_scan_595_if.sv | 28 ++
 rtl/seg_scan_595.sv | 209 ++++++++++++++++++++
 tb/tb_seg_scan_595.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_595_if.sv
// Display bus between a host and seg_scan_595: value/sign/points/enable in, 595 serial lines out.
// The dim field exists only when SEG_DIM_EN is defined.
interface seg_scan_595_if #(
  parameter int DIGITS = 6,
  parameter int DATA_W = 20
);
  logic [DATA_W-1:0] data;
  logic [DIGITS-1:0] point;
  logic              sign;
  logic              seg_en;
  logic              shcp;
  logic              stcp;
  logic              ds;
  logic              oe;
  logic              frame_start;
`ifdef SEG_DIM_EN
  logic [3:0]        dim;
  modport master (output data, point, sign, seg_en, dim,
                  input  shcp, stcp, ds, oe, frame_start);
  modport slave  (input  data, point, sign, seg_en, dim,
                  output shcp, stcp, ds, oe, frame_start);
`else
  modport master (output data, point, sign, seg_en,
                  input  shcp, stcp, ds, oe, frame_start);
  modport slave  (input  data, point, sign, seg_en,
                  output shcp, stcp, ds, oe, frame_start);
`endif
endinterface

// File: rtl/seg_scan_595.sv
// Multiplexed DIGITS-digit 7-segment scanner: frame snapshot, serial double-dabble, blanking/sign/overflow, 74HC595 shift-out.
// Optional SEG_DIM_EN adds a 4-bit dim input that gates oe for a fraction of each digit slot.
module seg_scan_595 #(
  parameter int DIGITS    = 6,
  parameter int DATA_W    = 20,
  parameter int SCAN_CYC  = 50000,
  parameter int SHCP_HALF = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  seg_scan_595_if.slave  bus
);

  localparam int WW = DIGITS + 8;
  localparam int CW = $clog2(SCAN_CYC);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW = $clog2(2 * SHCP_HALF) + 1;
  localparam int BW = $clog2(WW);
  localparam int NW = $clog2(DATA_W);
  localparam logic [63:0] MAXV = 64'(10 ** DIGITS) - 64'd1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_BLANK = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_LATCH = 3'd5;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       dig;
  logic [2:0]          state;
  logic [DATA_W-1:0]   bin;
  logic [4*DIGITS-1:0] bcd, bcd_adj;
  logic [DIGITS-1:0]   point_q;
  logic                sign_q, en_q, ovf_val;
  logic [NW-1:0]       conv_n;
  logic [7:0]          segs     [DIGITS];
  logic [7:0]          seg_next [DIGITS];
  logic [WW-1:0]       sreg, word;
  logic [DIGITS-1:0]   sel;
  logic [BW-1:0]       bitc;
  logic [TW-1:0]       tmr;
  logic [IW-1:0]       msd;
  logic                ovf, frame_go, oe_next;

  function automatic logic [7:0] numeral(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign frame_go = (cnt == '0) && (dig == '0);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // msd stays 0 for a zero value so digit 0 always shows a numeral
  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++)
      if (bcd[4*i +: 4] != 4'd0) msd = IW'(i);
    ovf = ovf_val | (sign_q & (msd == IW'(DIGITS - 1)));
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      seg_next[k] = 8'hFF;
      if (en_q) begin
        if (ovf)                                   seg_next[k] = 8'hBF;
        else if (k <= int'(msd))                   seg_next[k] = numeral(bcd[4*k +: 4]);
        else if (sign_q && (k == int'(msd) + 1))   seg_next[k] = 8'hBF;
        if (point_q[k]) seg_next[k][7] = 1'b0;
      end
    end
  end

  always_comb begin
    sel      = '0;
    sel[dig] = 1'b1;
    word     = {sel, segs[dig]};
  end

`ifdef SEG_DIM_EN
  logic [3:0]  dim_q, dim_eff;
  logic [31:0] thr;

  always_comb begin
    dim_eff = frame_go ? bus.dim : dim_q;
    thr     = ((32'(dim_eff) + 32'd1) * 32'(SCAN_CYC)) >> 4;
    oe_next = (32'(cnt) >= thr);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)       dim_q <= '0;
    else if (frame_go) dim_q <= bus.dim;
  end
`else
  assign oe_next = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt             <= '0;
      dig             <= '0;
      state           <= S_IDLE;
      bin             <= '0;
      bcd             <= '0;
      point_q         <= '0;
      sign_q          <= 1'b0;
      en_q            <= 1'b0;
      ovf_val         <= 1'b0;
      conv_n          <= '0;
      sreg            <= '0;
      bitc            <= '0;
      tmr             <= '0;
      for (int k = 0; k < DIGITS; k++) segs[k] <= 8'hFF;
      bus.shcp        <= 1'b0;
      bus.stcp        <= 1'b0;
      bus.ds          <= 1'b0;
      bus.oe          <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= 1'b0;
      bus.oe          <= oe_next;

      if (cnt == CW'(SCAN_CYC - 1)) begin
        cnt <= '0;
        dig <= (dig == IW'(DIGITS - 1)) ? '0 : dig + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (cnt == '0) begin
        if (dig == '0) begin
          bin             <= bus.data;
          point_q         <= bus.point;
          sign_q          <= bus.sign;
          en_q            <= bus.seg_en;
          ovf_val         <= (64'(bus.data) > MAXV);
          bcd             <= '0;
          conv_n          <= '0;
          bus.frame_start <= 1'b1;
          state           <= S_CONV;
        end else begin
          state <= S_LOAD;
        end
      end else begin
        case (state)
          S_CONV: begin
            {bcd, bin} <= {bcd_adj, bin} << 1;
            conv_n     <= conv_n + 1'b1;
            if (conv_n == NW'(DATA_W - 1)) state <= S_BLANK;
          end
          S_BLANK: begin
            segs  <= seg_next;
            state <= S_LOAD;
          end
          S_LOAD: begin
            sreg     <= word;
            bus.ds   <= word[WW-1];
            bus.shcp <= 1'b0;
            tmr      <= '0;
            bitc     <= '0;
            state    <= S_SHIFT;
          end
          S_SHIFT: begin
            // ds only moves on the falling shcp edge so it is stable at every rising edge
            tmr <= tmr + 1'b1;
            if (tmr == '0) bus.shcp <= 1'b1;
            if (tmr == TW'(SHCP_HALF)) begin
              bus.shcp <= 1'b0;
              bus.ds   <= sreg[WW-2];
              sreg     <= {sreg[WW-2:0], 1'b0};
            end
            if (tmr == TW'(2 * SHCP_HALF - 1)) begin
              tmr <= '0;
              if (bitc == BW'(WW - 1)) state <= S_LATCH;
              else                     bitc  <= bitc + 1'b1;
            end
          end
          S_LATCH: begin
            tmr <= tmr + 1'b1;
            if (tmr == '0) bus.stcp <= 1'b1;
            if (tmr == TW'(SHCP_HALF)) begin
              bus.stcp <= 1'b0;
              bus.ds   <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_595.sv
// Directed bench for seg_scan_595: a 595-chain model rebuilds each latched {sel, seg} word for checking.
module tb_seg_scan_595;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  seg_scan_595_if #(.DIGITS(6), .DATA_W(20)) io ();

  seg_scan_595 #(.DIGITS(6), .DATA_W(20), .SCAN_CYC(200), .SHCP_HALF(1)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (io)
  );

  always #5 sys_clk = ~sys_clk;

  logic [13:0] sr        = '0;
  logic [13:0] last_word = '0;
  logic [7:0]  lat [6];
  int          shcp_n = 0, stcp_n = 0, bad_edges = 0, bad_sel = 0;

  always @(posedge io.shcp or posedge io.stcp or posedge sys_rst) begin
    if (sys_rst) begin
      shcp_n = 0;
    end else if (io.stcp) begin
      last_word = sr;
      stcp_n++;
      if (shcp_n != 14) bad_edges++;
      shcp_n = 0;
      if ($onehot(sr[13:8])) begin
        for (int k = 0; k < 6; k++) if (sr[8+k]) lat[k] = sr[7:0];
      end else begin
        bad_sel++;
      end
    end else begin
      sr = {sr[12:0], io.ds};
      shcp_n++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_frame;
    bit hit = 1'b0;
    for (int i = 0; i < 1500 && !hit; i++) begin
      @(posedge sys_clk);
      #1;
      hit = io.frame_start;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL frame_start_timeout got 0 want 1");
    end
  endtask

  task automatic set_in(input logic [19:0] d, input logic [5:0] p, input logic s, input logic e);
    io.data   = d;
    io.point  = p;
    io.sign   = s;
    io.seg_en = e;
  endtask

  // Frame after the snapshot edge: returns latch count and malformed-word count seen within it.
  task automatic run_frame(output int nst, output int nbad);
    int s0, e0;
    wait_frame();
    s0 = stcp_n;
    e0 = bad_edges + bad_sel;
    wait_frame();
    nst  = stcp_n - s0;
    nbad = bad_edges + bad_sel - e0;
  endtask

  task automatic test_reset;
    step(3);
    checks++; if (io.shcp !== 1'b0)        begin errors++; $display("FAIL rst_shcp got %b want 0", io.shcp); end
    checks++; if (io.stcp !== 1'b0)        begin errors++; $display("FAIL rst_stcp got %b want 0", io.stcp); end
    checks++; if (io.ds !== 1'b0)          begin errors++; $display("FAIL rst_ds got %b want 0", io.ds); end
    checks++; if (io.oe !== 1'b1)          begin errors++; $display("FAIL rst_oe got %b want 1", io.oe); end
    checks++; if (io.frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b want 0", io.frame_start); end
    sys_rst = 1'b0;
    step(1);
    checks++; if (io.frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b want 1", io.frame_start); end
    checks++; if (io.oe !== 1'b0)          begin errors++; $display("FAIL oe_after_release got %b want 0", io.oe); end
    step(1);
    checks++; if (io.frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_pulse got %b want 0", io.frame_start); end
  endtask

  task automatic test_basic;
    logic [7:0] exp [6];
    int nst, nbad, oe_hi;
    exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF};
    set_in(20'd1234, 6'b000000, 1'b0, 1'b1);
    run_frame(nst, nbad);
    checks++; if (nst !== 6)  begin errors++; $display("FAIL basic_stcp_per_frame got %0d want 6", nst); end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL basic_word_shape bad_words %0d want 0", nbad); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (lat[k] !== exp[k]) begin errors++; $display("FAIL basic d%0d got %h want %h", k, lat[k], exp[k]); end
    end
`ifndef SEG_DIM_EN
    oe_hi = 0;
    for (int i = 0; i < 200; i++) begin step(1); if (io.oe !== 1'b0) oe_hi++; end
    checks++; if (oe_hi !== 0) begin errors++; $display("FAIL oe_steady high_cycles %0d want 0", oe_hi); end
`endif
  endtask

  task automatic test_sign_dp;
    logic [7:0] exp [6];
    int nst, nbad;
    exp = '{8'h82, 8'h12, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
    set_in(20'd56, 6'b000010, 1'b1, 1'b1);
    run_frame(nst, nbad);
    checks++; if (nst !== 6) begin errors++; $display("FAIL sign_stcp_per_frame got %0d want 6", nst); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (lat[k] !== exp[k]) begin errors++; $display("FAIL sign_dp d%0d got %h want %h", k, lat[k], exp[k]); end
    end
  endtask

  task automatic test_zero;
    logic [7:0] exp [6];
    int nst, nbad;
    exp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    set_in(20'd0, 6'b000000, 1'b0, 1'b1);
    run_frame(nst, nbad);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (lat[k] !== exp[k]) begin errors++; $display("FAIL zero d%0d got %h want %h", k, lat[k], exp[k]); end
    end
  endtask

  task automatic test_overflow;
    logic [19:0] pd [3];
    logic        ps [3];
    logic [7:0]  pe [3];
    int nst, nbad;
    pd = '{20'd1000000, 20'd123456, 20'd999999};
    ps = '{1'b0, 1'b1, 1'b0};
    pe = '{8'hBF, 8'hBF, 8'h90};
    for (int p = 0; p < 3; p++) begin
      set_in(pd[p], 6'b000000, ps[p], 1'b1);
      run_frame(nst, nbad);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (lat[k] !== pe[p]) begin errors++; $display("FAIL overflow%0d d%0d got %h want %h", p, k, lat[k], pe[p]); end
      end
    end
  endtask

  task automatic test_blank;
    logic [7:0] exp [6];
    int nst, nbad;
    set_in(20'd1234, 6'b111111, 1'b1, 1'b0);
    run_frame(nst, nbad);
    checks++; if (nst !== 6) begin errors++; $display("FAIL blank_stcp_per_frame got %0d want 6", nst); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (lat[k] !== 8'hFF) begin errors++; $display("FAIL seg_en_off d%0d got %h want ff", k, lat[k]); end
    end
    exp = '{8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    set_in(20'd7, 6'b100001, 1'b0, 1'b1);
    run_frame(nst, nbad);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (lat[k] !== exp[k]) begin errors++; $display("FAIL dp_on_blank d%0d got %h want %h", k, lat[k], exp[k]); end
    end
  endtask

  task automatic test_midframe;
    logic [7:0] exp [6];
    int s0;
    exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF};
    set_in(20'd1234, 6'b000000, 1'b0, 1'b1);
    wait_frame();
    s0 = stcp_n;
    step(620);
    io.data = 20'd9;
    wait_frame();
    checks++; if (stcp_n - s0 !== 6) begin errors++; $display("FAIL midframe_stcp got %0d want 6", stcp_n - s0); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (lat[k] !== exp[k]) begin errors++; $display("FAIL midframe_hold d%0d got %h want %h", k, lat[k], exp[k]); end
    end
    exp = '{8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wait_frame();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (lat[k] !== exp[k]) begin errors++; $display("FAIL midframe_next d%0d got %h want %h", k, lat[k], exp[k]); end
    end
  endtask

  task automatic test_reset_midshift;
    int   n = 0, s0, e0;
    logic prev = 1'b0;
    bit   got = 1'b0;
    set_in(20'd1234, 6'b000000, 1'b0, 1'b1);
    wait_frame();
    step(190);
    // digit-1 slot: the fifth bit shifted is sel[1]=1, so ds is high when reset hits
    for (int i = 0; i < 200 && n < 5; i++) begin
      step(1);
      if (io.shcp && !prev) n++;
      prev = io.shcp;
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL midshift_pulses got %0d want 5", n); end
    checks++; if (io.ds !== 1'b1) begin errors++; $display("FAIL midshift_ds_before got %b want 1", io.ds); end
    sys_rst = 1'b1;
    #1;
    checks++; if (io.shcp !== 1'b0) begin errors++; $display("FAIL midrst_shcp got %b want 0", io.shcp); end
    checks++; if (io.stcp !== 1'b0) begin errors++; $display("FAIL midrst_stcp got %b want 0", io.stcp); end
    checks++; if (io.ds !== 1'b0)   begin errors++; $display("FAIL midrst_ds got %b want 0", io.ds); end
    checks++; if (io.oe !== 1'b1)   begin errors++; $display("FAIL midrst_oe got %b want 1", io.oe); end
    step(3);
    sys_rst = 1'b0;
    s0 = stcp_n;
    e0 = bad_edges;
    for (int i = 0; i < 300 && !got; i++) begin
      step(1);
      got = (stcp_n != s0);
    end
    checks++; if (!got) begin errors++; $display("FAIL after_rst_latch_timeout got 0 want 1"); end
    checks++;
    if (last_word !== {6'b000001, 8'h99}) begin
      errors++; $display("FAIL after_rst_word got %h want %h", last_word, {6'b000001, 8'h99});
    end
    checks++; if (bad_edges - e0 !== 0) begin errors++; $display("FAIL after_rst_edges bad %0d want 0", bad_edges - e0); end
  endtask

`ifdef SEG_DIM_EN
  task automatic test_dim;
    int lo = 0;
    io.dim = 4'd3;
    wait_frame();
    wait_frame();
    for (int i = 0; i < 200; i++) begin step(1); if (io.oe === 1'b0) lo++; end
    checks++; if (lo !== 50) begin errors++; $display("FAIL dim3_oe_low got %0d want 50", lo); end
    io.dim = 4'd15;
  endtask
`endif

  initial begin
    set_in(20'd0, 6'b000000, 1'b0, 1'b1);
`ifdef SEG_DIM_EN
    io.dim = 4'd15;
`endif
    test_reset();
    test_basic();
    test_sign_dp();
    test_zero();
    test_overflow();
    test_blank();
    test_midframe();
    test_reset_midshift();
`ifdef SEG_DIM_EN
    test_dim();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
